link_tx_ser: RTL and testbench

- Serial link-layer transmitter, one `sys_clk` domain.
- On `tx_start` it fetches a frame payload from an external tx buffer RAM (read port) and drives it bit-serially on `lb_txd`/`lb_txen`.
- Frame format: preamble, SFD, length, payload, CRC-16.
- It is the sending-end counterpart of the existing link receiver; its frame format matches what that receiver accepts.

---
 rtl/link_pkg.sv | 20 ++
 rtl/link_crc16_byte.sv | 20 ++
 rtl/link_tx_ser.sv | 213 +++++++++++++++++++++
 tb/tb_link_tx_ser.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared link-layer types and constants for the serial link transmitter/receiver.
// The CRC state only exists when LINK_TX_CRC_EN is defined.
package link_pkg;
  localparam int          LEN_W         = 11;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_LEN,
    ST_PAY,
`ifdef LINK_TX_CRC_EN
    ST_CRC,
`endif
    ST_GAP
  } state_t;
endpackage

// File: rtl/link_crc16_byte.sv
// Combinational CRC-16/CCITT-FALSE update over one byte, MSB first.
// Shared by the link transmitter and receiver.
module link_crc16_byte
  import link_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else       c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end
endmodule

// File: rtl/link_tx_ser.sv
// Serial link transmitter: preamble, SFD, length, payload, optional CRC-16.
// Define LINK_TX_CRC_EN to append the CRC-16 bytes after the payload.
module link_tx_ser
  import link_pkg::*;
#(
  parameter int         PRE_BYTES = 7,
  parameter logic [7:0] SFD_BYTE  = 8'hD5,
  parameter int         BIT_DIV   = 4,
  parameter int         IFG_BITS  = 96
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [LEN_W-1:0] tx_data_len,
  output logic             tx_buf_rden,
  output logic [LEN_W-1:0] tx_buf_raddr,
  input  logic [7:0]       tx_buf_rdata,
  output logic             lb_txd,
  output logic             lb_txen,
  output logic             tx_busy,
  output logic             tx_done
);
  localparam int GAP_CYC = IFG_BITS * BIT_DIV;
  localparam int GAP_W   = $clog2(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
  localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PRE_BYTES - 1);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] byte_cnt;
  logic [7:0]       div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       sh;
  logic [7:0]       nxt_byte;
  logic             rd_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [LEN_W:0]   cnt_p2;
  logic             bit_end;
  logic             byte_end;
  logic             tx_on;
  logic             len_zero;

`ifdef LINK_TX_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_nxt;

  link_crc16_byte u_crc (
    .crc_in  (crc),
    .data    (nxt_byte),
    .crc_out (crc_nxt)
  );
`endif

  assign cnt_p2   = {1'b0, byte_cnt} + (LEN_W+1)'(2);
  assign bit_end  = (div_cnt == DIV_LAST);
  assign byte_end = bit_end && (bit_cnt == 3'd7);
  assign tx_on    = (state != ST_IDLE) && (state != ST_GAP);
  assign len_zero = (len_q == '0);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      byte_cnt     <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      sh           <= '0;
      nxt_byte     <= '0;
      rd_q         <= 1'b0;
      gap_cnt      <= '0;
      tx_buf_rden  <= 1'b0;
      tx_buf_raddr <= '0;
      lb_txd       <= 1'b0;
      lb_txen      <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
`ifdef LINK_TX_CRC_EN
      crc          <= CRC16_INIT;
`endif
    end else begin
      tx_buf_rden <= 1'b0;
      tx_done     <= 1'b0;
      rd_q        <= tx_buf_rden;
      if (rd_q) nxt_byte <= tx_buf_rdata;

      unique case (state)
        ST_IDLE: begin
          lb_txen <= 1'b0;
          lb_txd  <= 1'b0;
          if (tx_start) begin
            len_q    <= tx_data_len;
            tx_busy  <= 1'b1;
            state    <= ST_PRE;
            sh       <= PREAMBLE_BYTE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
`ifdef LINK_TX_CRC_EN
            crc      <= CRC16_INIT;
`endif
            if (tx_data_len != '0) begin
              tx_buf_rden  <= 1'b1;
              tx_buf_raddr <= '0;
            end
          end
        end
        ST_GAP: begin
          lb_txen <= 1'b0;
          lb_txd  <= 1'b0;
          tx_done <= lb_txen;
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: begin
          lb_txen <= 1'b1;
          lb_txd  <= sh[7];
          if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            sh      <= {sh[6:0], 1'b0};
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase

      // Byte boundary: reload the shifter and advance the frame field.
      if (tx_on && byte_end) begin
        unique case (state)
          ST_PRE: begin
            if (byte_cnt == PRE_LAST) begin
              state    <= ST_SFD;
              sh       <= SFD_BYTE;
              byte_cnt <= '0;
            end else begin
              sh       <= PREAMBLE_BYTE;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          ST_SFD: begin
            state    <= ST_LEN;
            sh       <= {5'b0, len_q[10:8]};
            byte_cnt <= '0;
          end
          ST_LEN: begin
            if (byte_cnt == '0) begin
              sh       <= len_q[7:0];
              byte_cnt <= LEN_W'(1);
            end else if (!len_zero) begin
              state    <= ST_PAY;
              sh       <= nxt_byte;
              byte_cnt <= '0;
`ifdef LINK_TX_CRC_EN
              crc      <= crc_nxt;
`endif
              if (len_q > LEN_W'(1)) begin
                tx_buf_rden  <= 1'b1;
                tx_buf_raddr <= LEN_W'(1);
              end
            end else begin
`ifdef LINK_TX_CRC_EN
              state    <= ST_CRC;
              sh       <= crc[15:8];
              byte_cnt <= '0;
`else
              state    <= ST_GAP;
              gap_cnt  <= '0;
`endif
            end
          end
          ST_PAY: begin
            if (byte_cnt == len_q - LEN_W'(1)) begin
`ifdef LINK_TX_CRC_EN
              state    <= ST_CRC;
              sh       <= crc[15:8];
              byte_cnt <= '0;
`else
              state    <= ST_GAP;
              gap_cnt  <= '0;
`endif
            end else begin
              sh       <= nxt_byte;
              byte_cnt <= byte_cnt + 1'b1;
`ifdef LINK_TX_CRC_EN
              crc      <= crc_nxt;
`endif
              if (cnt_p2 < {1'b0, len_q}) begin
                tx_buf_rden  <= 1'b1;
                tx_buf_raddr <= cnt_p2[LEN_W-1:0];
              end
            end
          end
`ifdef LINK_TX_CRC_EN
          ST_CRC: begin
            if (byte_cnt == '0) begin
              sh       <= crc[7:0];
              byte_cnt <= LEN_W'(1);
            end else begin
              state    <= ST_GAP;
              gap_cnt  <= '0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_link_tx_ser.sv
// Directed bench for link_tx_ser: decodes the line and checks frames,
// timing, buffer reads, ignored starts and mid-frame reset.
module tb_link_tx_ser;
  localparam int BD = 4;
`ifdef LINK_TX_CRC_EN
  localparam int CB = 2;
`else
  localparam int CB = 0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_start = 1'b0;
  logic [10:0] tx_data_len = '0;
  logic        tx_buf_rden;
  logic [10:0] tx_buf_raddr;
  logic [7:0]  tx_buf_rdata;
  logic        lb_txd;
  logic        lb_txen;
  logic        tx_busy;
  logic        tx_done;

  link_tx_ser dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .tx_start     (tx_start),
    .tx_data_len  (tx_data_len),
    .tx_buf_rden  (tx_buf_rden),
    .tx_buf_raddr (tx_buf_raddr),
    .tx_buf_rdata (tx_buf_rdata),
    .lb_txd       (lb_txd),
    .lb_txen      (lb_txen),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] mem [0:2047];
  always @(posedge sys_clk)
    if (tx_buf_rden) tx_buf_rdata <= mem[tx_buf_raddr];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h want 'h%0h", tag, got, exp);
    end
  endtask

  // Line monitor: mid-bit sampling, byte assembly, read-order tracking.
  logic [7:0] rx_b[$];
  logic [7:0] sr;
  int ph = 0, nb = 0;
  int txen_tot = 0, done_tot = 0, idle_bad = 0;
  int rd_tot = 0, rd_bad = 0, rd_exp = 0;
  int low_run = 0, last_gap = 0;

  always @(negedge sys_clk) begin
    if (lb_txen) begin
      if (low_run != 0) last_gap = low_run;
      low_run = 0;
      txen_tot++;
      if (ph == BD/2) begin
        sr = {sr[6:0], lb_txd};
        nb++;
        if (nb == 8) begin
          rx_b.push_back(sr);
          nb = 0;
        end
      end
      ph = (ph == BD-1) ? 0 : ph + 1;
    end else begin
      low_run++;
      ph = 0;
      nb = 0;
      if (lb_txd) idle_bad++;
    end
    if (tx_done) done_tot++;
    if (!tx_busy && !tx_buf_rden) rd_exp = 0;
    if (tx_buf_rden) begin
      if (tx_buf_raddr != 11'(rd_exp)) rd_bad++;
      rd_exp++;
      rd_tot++;
    end
  end

  function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                          input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  logic [7:0] exp_b[$];

  task automatic build_exp(input logic [10:0] len);
    logic [15:0] c;
    exp_b.delete();
    repeat (7) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    exp_b.push_back({5'b0, len[10:8]});
    exp_b.push_back(len[7:0]);
    c = 16'hFFFF;
    for (int i = 0; i < int'(len); i++) begin
      exp_b.push_back(mem[i]);
      c = crc_upd(c, mem[i]);
    end
`ifdef LINK_TX_CRC_EN
    exp_b.push_back(c[15:8]);
    exp_b.push_back(c[7:0]);
`endif
  endtask

  int b_b, b_t, b_d, b_r, b_rb, b_i;

  task automatic frame_begin(input string tag, input logic [10:0] len);
    b_b = rx_b.size();
    b_t = txen_tot;
    b_d = done_tot;
    b_r = rd_tot;
    b_rb = rd_bad;
    b_i = idle_bad;
    @(negedge sys_clk);
    tx_start = 1'b1;
    tx_data_len = len;
    @(negedge sys_clk);
    tx_start = 1'b0;
    chk({tag, "_lat1_txen"}, lb_txen, 1'b0);
    chk({tag, "_lat1_busy"}, tx_busy, 1'b1);
    @(negedge sys_clk);
    chk({tag, "_lat2_txen"}, lb_txen, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (tx_busy && k < 80000) begin
      @(negedge sys_clk);
      k++;
    end
    if (tx_busy) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic frame_end(input string tag, input logic [10:0] len);
    int d = 0;
    build_exp(len);
    chk({tag, "_nbytes"}, rx_b.size() - b_b, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      if (b_b + i < rx_b.size() && rx_b[b_b + i] !== exp_b[i]) d++;
    chk({tag, "_bytes"}, d, 0);
    chk({tag, "_txen_cyc"}, txen_tot - b_t, (10 + int'(len) + CB) * 8 * BD);
    chk({tag, "_done"}, done_tot - b_d, 1);
    chk({tag, "_reads"}, rd_tot - b_r, len);
    chk({tag, "_rd_order"}, rd_bad - b_rb, 0);
    chk({tag, "_idle_txd"}, idle_bad - b_i, 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);

    repeat (3) @(negedge sys_clk);
    chk("rst_txen", lb_txen, 1'b0);
    chk("rst_txd", lb_txd, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_rden", tx_buf_rden, 1'b0);
    chk("rst_raddr", tx_buf_raddr, 11'd0);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    // "123456789", CRC 0x29B1
    frame_begin("f9", 11'd9);
    wait_idle("f9");
    frame_end("f9", 11'd9);
    chk("f9_len_hi", rx_b[b_b + 8], 8'h00);
    chk("f9_len_lo", rx_b[b_b + 9], 8'h09);
    chk("f9_pay0", rx_b[b_b + 10], 8'h31);
    chk("f9_pay8", rx_b[b_b + 18], 8'h39);
`ifdef LINK_TX_CRC_EN
    chk("f9_crc_hi", rx_b[b_b + 19], 8'h29);
    chk("f9_crc_lo", rx_b[b_b + 20], 8'hB1);
    chk("f9_txen_672", txen_tot - b_t, 672);
`else
    chk("f9_txen_608", txen_tot - b_t, 608);
`endif

    frame_begin("f0", 11'd0);
    wait_idle("f0");
    frame_end("f0", 11'd0);
    chk("f0_no_rden", rd_tot - b_r, 0);
`ifdef LINK_TX_CRC_EN
    chk("f0_crc_hi", rx_b[b_b + 10], 8'hFF);
    chk("f0_crc_lo", rx_b[b_b + 11], 8'hFF);
    chk("f0_txen_384", txen_tot - b_t, 384);
`endif

    // starts during frame and during GAP must be ignored
    frame_begin("bb1", 11'd5);
    repeat (100) @(negedge sys_clk);
    tx_start = 1'b1;
    tx_data_len = 11'd3;
    @(negedge sys_clk);
    tx_start = 1'b0;
    begin
      int k = 0;
      while (!(tx_busy && !lb_txen) && k < 2000) begin
        @(negedge sys_clk);
        k++;
      end
      chk("bb_reach_gap", tx_busy && !lb_txen, 1'b1);
    end
    repeat (20) @(negedge sys_clk);
    tx_start = 1'b1;
    @(negedge sys_clk);
    tx_start = 1'b0;
    wait_idle("bb1");
    frame_end("bb1", 11'd5);
    frame_begin("bb2", 11'd4);
    wait_idle("bb2");
    frame_end("bb2", 11'd4);
    chk("bb_gap_min", last_gap >= 384, 1'b1);

    // reset while payload byte 5 is on the line
    b_b = rx_b.size();
    @(negedge sys_clk);
    tx_start = 1'b1;
    tx_data_len = 11'd9;
    @(negedge sys_clk);
    tx_start = 1'b0;
    begin
      int k = 0;
      while (rx_b.size() - b_b < 15 && k < 2000) begin
        @(negedge sys_clk);
        k++;
      end
      chk("rm_reach_pay5", rx_b.size() - b_b, 15);
    end
    repeat (5) @(negedge sys_clk);
    rst = 1'b0;
    #1;
    chk("rm_txen", lb_txen, 1'b0);
    chk("rm_busy", tx_busy, 1'b0);
    chk("rm_txd", lb_txd, 1'b0);
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    frame_begin("rm_post", 11'd9);
    wait_idle("rm_post");
    frame_end("rm_post", 11'd9);

    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
    frame_begin("fmax", 11'd2047);
    wait_idle("fmax");
    frame_end("fmax", 11'd2047);
    chk("fmax_len_hi", rx_b[b_b + 8], 8'h07);
    chk("fmax_len_lo", rx_b[b_b + 9], 8'hFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
